// File: rtl/mccpu_mem_responder.sv
// Memory-side responder for the multicycle CPU: word-addressed RAM behind a request/ready
// handshake, with a fixed number of wait states and an error response for bad requests.
module mccpu_mem_responder #(
  parameter int unsigned AW          = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        rmem,
  input  logic        wmem,
  output logic [31:0] frommem,
  output logic        ready,
  output logic        err
);

  localparam int unsigned Depth    = 2 ** AW;
  localparam int unsigned WaitM1   = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;
  localparam logic [3:0]  WaitLast = WaitM1[3:0];

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            wr_q;
  logic            bad_q;
  logic            ready_q;
  logic            err_q;
  logic [31:0]     frommem_q;
  logic [31:0]     mem_q [Depth];

  logic            in_idle;
  logic            accept;
  logic            req_bad;
  logic            finish;
  logic [AW-1:0]   cur_idx;
  logic [31:0]     cur_wdata;
  logic            cur_wr;
  logic            cur_bad;

  assign in_idle = (state_q == StIdle);
  assign accept  = in_idle & (rmem | wmem);
  assign req_bad = (addr[1:0] != 2'b00) | ((addr >> (AW + 2)) != 32'd0) | (rmem & wmem);

  // With zero wait states the completion edge is the accept edge, so the live request is
  // used; otherwise the latched copy is.
  always_comb begin
    cur_idx   = in_idle ? addr[AW+1:2] : idx_q;
    cur_wdata = in_idle ? wdata : wdata_q;
    cur_wr    = in_idle ? wmem : wr_q;
    cur_bad   = in_idle ? req_bad : bad_q;
    finish    = (accept & (WAIT_CYCLES == 0)) | ((state_q == StBusy) & (cnt_q == 4'd0));
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      wdata_q   <= 32'd0;
      wr_q      <= 1'b0;
      bad_q     <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      frommem_q <= 32'd0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      if (finish) begin
        ready_q <= 1'b1;
        err_q   <= cur_bad;
        if (cur_bad) begin
          frommem_q <= 32'd0;
        end else if (!cur_wr) begin
          frommem_q <= mem_q[cur_idx];
        end
      end
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            idx_q   <= addr[AW+1:2];
            wdata_q <= wdata;
            wr_q    <= wmem;
            bad_q   <= req_bad;
            if (WAIT_CYCLES == 0) begin
              state_q <= StDone;
            end else begin
              state_q <= StBusy;
              cnt_q   <= WaitLast;
            end
          end
        end
        StBusy: begin
          if (cnt_q == 4'd0) begin
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Array is deliberately not reset; a write commits only on the completion edge.
  always_ff @(posedge clock) begin
    if (finish && cur_wr && !cur_bad) begin
      mem_q[cur_idx] <= cur_wdata;
    end
  end

  assign frommem = frommem_q;
  assign ready   = ready_q;
  assign err     = err_q;

endmodule
